// File: rtl/bram_pkg.sv
// bram_pkg: shared constants and helpers for the byte-lane block RAM (RDW policy codes, lane parity, range check)
package bram_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  localparam int LANE_MAX = 64;
  function automatic logic lane_parity(input logic [LANE_MAX-1:0] d);
    return ^d;
  endfunction
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/bram_mem_be_if.sv
// bram_mem_be_if: write/read request bus of bram_mem_be; master drives requests, slave returns rdata/rvalid/rdw_hit/perr
interface bram_mem_be_if
  import bram_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int LANEW = 8,
  parameter int ADDRW = 9
);
  localparam int NLANES = DATAW / LANEW;
  logic              wen;
  logic [ADDRW-1:0]  waddr;
  logic [DATAW-1:0]  wdata;
  logic [NLANES-1:0] wbe;
  logic              ren;
  logic [ADDRW-1:0]  raddr;
  logic [DATAW-1:0]  rdata;
  logic              rvalid;
  logic              rdw_hit;
  logic              perr;
  modport master (output wen, waddr, wdata, wbe, ren, raddr, input rdata, rvalid, rdw_hit, perr);
  modport slave (input wen, waddr, wdata, wbe, ren, raddr, output rdata, rvalid, rdw_hit, perr);
endinterface

// File: rtl/bram_lane.sv
// bram_lane: one lane-wide simple dual-port array with registered read; ports clk, rst_n, we/waddr/wdata write, re/raddr read, q read register
module bram_lane
  import bram_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 512,
  parameter int ADDRW = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic             re,
  input  logic [ADDRW-1:0] raddr,
  output logic [W-1:0]     q
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register uses the array's output clear so rdata is 0 out of reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (re) q <= mem[raddr];
endmodule

// File: rtl/bram_mem_be.sv
// bram_mem_be: dual-port RAM with byte-lane writes, timed rvalid, RDW policy, range guard; ports clk, rst_n, bus (bram_mem_be_if.slave); BRAM_MEM_BE_PARITY_EN adds per-lane parity/perr
module bram_mem_be
  import bram_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int LANEW = 8,
  parameter int NLANES = DATAW / LANEW,
  parameter int DEPTH = 512,
  parameter int ADDRW = $clog2(DEPTH),
  parameter int OUT_REG = 0,
  parameter int RDW_MODE = RDW_OLD
) (
  input logic          clk,
  input logic          rst_n,
  bram_mem_be_if.slave bus
);
`ifdef BRAM_MEM_BE_PARITY_EN
  localparam int LW = LANEW + 1;
`else
  localparam int LW = LANEW;
`endif
  logic              r_wen;
  logic              r_ren;
  logic [NLANES-1:0] r_wbe;
  logic [ADDRW-1:0]  r_waddr;
  logic [ADDRW-1:0]  r_raddr;
  logic [DATAW-1:0]  r_wdata;
  logic              w_ok;
  logic              r_ok;
  logic              hit;
  logic              s2_valid;
  logic              s2_hit;
  logic              s2_oor;
  logic [NLANES-1:0] s2_byp;
  logic [NLANES-1:0] lane_err;
  logic [DATAW-1:0]  s2_wdata;
  logic [DATAW-1:0]  d2;
  logic              p2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wen <= 1'b0;
      r_ren <= 1'b0;
      r_wbe <= '0;
    end else begin
      r_wen <= bus.wen;
      r_ren <= bus.ren;
      r_wbe <= bus.wbe;
    end
  always_ff @(posedge clk) begin
    r_waddr <= bus.waddr;
    r_raddr <= bus.raddr;
    r_wdata <= bus.wdata;
  end
  assign w_ok = addr_in_range(32'(r_waddr), DEPTH);
  assign r_ok = addr_in_range(32'(r_raddr), DEPTH);
  // out-of-range reads never count as a collision, even if the write address matches
  assign hit = r_wen && r_ren && r_ok && (r_waddr == r_raddr);
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    logic [LW-1:0] wd;
    logic [LW-1:0] q;
`ifdef BRAM_MEM_BE_PARITY_EN
    assign wd = {lane_parity(LANE_MAX'(r_wdata[i*LANEW +: LANEW])), r_wdata[i*LANEW +: LANEW]};
    assign lane_err[i] = q[LANEW] ^ lane_parity(LANE_MAX'(q[LANEW-1:0]));
`else
    assign wd = r_wdata[i*LANEW +: LANEW];
`endif
    bram_lane #(.W(LW), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_lane (
      .clk(clk),
      .rst_n(rst_n),
      .we(r_wen && r_wbe[i] && w_ok),
      .waddr(r_waddr),
      .wdata(wd),
      .re(r_ren && r_ok),
      .raddr(r_raddr),
      .q(q)
    );
    assign d2[i*LANEW +: LANEW] = s2_oor ? '0 : s2_byp[i] ? s2_wdata[i*LANEW +: LANEW] : q[LANEW-1:0];
  end
`ifndef BRAM_MEM_BE_PARITY_EN
  assign lane_err = '0;
`endif
  // bypassed lanes carry fresh write data, so their stored parity is irrelevant
  assign p2 = !s2_oor && |(lane_err & ~s2_byp);
  // read-side tags only move on an accepted read so d2 holds between reads
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_hit   <= 1'b0;
      s2_oor   <= 1'b0;
      s2_byp   <= '0;
      s2_wdata <= '0;
    end else begin
      s2_valid <= r_ren;
      if (r_ren) begin
        s2_hit   <= hit;
        s2_oor   <= !r_ok;
        s2_byp   <= (RDW_MODE == RDW_NEW && hit) ? r_wbe : '0;
        s2_wdata <= r_wdata;
      end
    end
  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        bus.rdata   <= '0;
        bus.rvalid  <= 1'b0;
        bus.rdw_hit <= 1'b0;
        bus.perr    <= 1'b0;
      end else begin
        bus.rvalid  <= s2_valid;
        bus.rdw_hit <= s2_valid && s2_hit;
        bus.perr    <= s2_valid && p2;
        if (s2_valid) bus.rdata <= d2;
      end
  end else begin : g_direct
    assign bus.rdata   = d2;
    assign bus.rvalid  = s2_valid;
    assign bus.rdw_hit = s2_valid && s2_hit;
    assign bus.perr    = s2_valid && p2;
  end
endmodule

// File: doc/bram_mem_be.md
Name: bram_mem_be

Overview:
- Parametrised successor to the single-port-pair M20K memory wrapper: simple dual-port RAM (one write port, one read port) with byte-lane write enables, explicit read enable with valid tracking, optional output register stage, selectable read-during-write policy, and out-of-range address protection.
- Used as the storage primitive under the transpose buffers wherever partial-word writes or a timed read-valid are needed.

Parameters:
- DATAW, 32, word width in bits; must be a multiple of LANEW.
- LANEW, 8, byte-lane width in bits.
- NLANES, DATAW/LANEW, number of write-enable lanes (derived; do not override).
- DEPTH, 512, number of words; need not be a power of two.
- ADDRW, $clog2(DEPTH), address width.
- OUT_REG, 0, 0 = read latency 2; 1 = extra output register, read latency 3.
- RDW_MODE, 0, same-cycle read/write to one address: 0 = return old data, 1 = return new data (write-through bypass).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wen  in  1  write request
- waddr  in  ADDRW  write address
- wdata  in  DATAW  write data
- wbe  in  NLANES  per-lane write enable; lane i covers wdata[i*LANEW +: LANEW]
- ren  in  1  read request
- raddr  in  ADDRW  read address
- rdata  out  DATAW  read data
- rvalid  out  1  rdata valid strobe, one cycle per accepted read
- rdw_hit  out  1  pulses with rvalid when that read collided with a same-cycle write to the same address
- perr  out  1  parity error on current rvalid (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): clear input registers r_wen, r_ren, r_wbe and every output-side register; rdata=0, rvalid=0, rdw_hit=0, perr=0. Memory contents are not cleared. Memory is zero-initialised at configuration.
- Edge 1: register all inputs (wen, waddr, wdata, wbe, ren, raddr).
- Edge 2: if r_wen, write lanes with r_wbe[i]=1 to mem[r_waddr]; other lanes are untouched. r_wbe=0 with r_wen=1 is a no-op. If r_ren, capture mem[r_raddr] to the stage-2 data register and set stage-2 valid.
- OUT_REG=0: stage 2 drives rdata/rvalid (latency 2). OUT_REG=1: one more register stage (latency 3).
- rvalid follows ren with fixed latency. rdata holds its last value when rvalid=0; no clearing between reads.
- Back-to-back: one read and one write accepted every cycle, with no stalls.
- Collision: r_wen && r_ren && r_waddr==r_raddr at the same edge.
  - RDW_MODE=0: old word returned.
  - RDW_MODE=1: written lanes come from r_wdata; unwritten lanes come from the old word.
  - rdw_hit=1 with the matching rvalid in both modes.
- Write then read of the same address one cycle later: the read returns the new data; no collision.
- Out of range (address >= DEPTH): write is dropped; read returns 0 with rvalid=1 and no rdw_hit.
- Reset mid-operation: an in-flight write not yet committed at edge 2 is dropped. In-flight reads are discarded (rvalid stays 0).

Optional Feature:
- Macro: BRAM_MEM_BE_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, computed from r_wdata at write time.
  - On read, recompute parity per lane. perr=1 with rvalid if any lane mismatches. perr is pipelined identically to rdata.
  - Bypassed data (RDW_MODE=1) uses freshly computed parity, so it never flags.
  - Out-of-range reads never flag.
- Undefined: no parity storage; perr tied 0.

Decomposition:
- Package bram_pkg holds:
  - localparams RDW_OLD=0 and RDW_NEW=1
  - function lane_parity(LANEW-bit)
  - function addr_in_range(addr, DEPTH)
- Natural sub-module bram_lane: one LANEW-wide (+1 parity) M20K array with its own write enable, instantiated NLANES times. Top level holds the input registers, collision detect/bypass mux, valid pipeline and optional output stage.

Test Plan:
- Write 0xDEADBEEF @5 wbe=1111, then ren @5 -> rvalid 2 cycles after ren (3 with OUT_REG=1), rdata=0xDEADBEEF, rdw_hit=0.
- @5 holding 0xDEADBEEF, write 0x11223344 wbe=0101, read @5 -> 0xDE22BE44.
- Same-cycle write 0xAAAAAAAA wbe=1111 and read @7 (old 0x0) -> RDW_MODE=0: rdata=0x0; RDW_MODE=1: 0xAAAAAAAA; rdw_hit=1 in both.
- DEPTH=500: write @510 = 0x1234, then read @510 -> rdata=0, rvalid=1. Read @(510 mod 512)=510 aliasing check: @254 unchanged.
- Stream 16 reads on consecutive cycles; assert rst_n low mid-stream for 1 cycle -> rvalid/rdata clear immediately; no rvalid for reads issued within the 2 cycles before reset; a write issued the cycle before reset is not committed.
- With BRAM_MEM_BE_PARITY_EN, force-flip one stored bit of lane 2 @9 via hierarchical deposit, then read @9 -> perr=1 with rvalid. Same read without the macro -> perr=0.
